// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the fetch PC, selects the next PC (sequential, branch, j/jal, jr) and
// fills the IF/ID pipeline register with stall, flush and fetch-fault tagging.
// Branches and jumps are resolved in D and have one architectural delay slot.
module ifu_fetch #(
  parameter logic [31:0] PC_INIT  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_d,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16_d,
  input  logic [25:0] index26_d,
  input  logic [31:0] rs_fwd_d,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        fault_d
);

  // Exclusive upper end of instruction memory, kept 33 bits wide so a memory
  // placed near the top of the address space cannot wrap the comparison.
  localparam logic [32:0] PC_LIMIT = {1'b0, PC_INIT} + (33'(IM_WORDS) << 2);

  localparam logic [1:0] SEL_SEQ    = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JUMP   = 2'd2;
  localparam logic [1:0] SEL_JR     = 2'd3;

  logic [31:0] fetchPc_q, fetchPc_d;
  logic [31:0] ifidInstr_q, ifidInstr_d;
  logic [31:0] ifidPc_q, ifidPc_d;
  logic [31:0] ifidPc8_q, ifidPc8_d;
  logic        ifidValid_q, ifidValid_d;
  logic        ifidFault_q, ifidFault_d;

  logic [31:0] pcPlus4;
  logic [31:0] pcPlus8;
  logic [31:0] branchOffset;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic [31:0] nextPc;
  logic        fetchFault;

  // Candidate targets; branch and jump targets are relative to the D-stage PC,
  // i.e. the control-transfer instruction itself, not the delay slot.
  always_comb begin
    pcPlus4      = fetchPc_q + 32'd4;
    pcPlus8      = fetchPc_q + 32'd8;
    branchOffset = {{14{imm16_d[15]}}, imm16_d, 2'b00};
    branchTarget = ifidPc_q + 32'd4 + branchOffset;
    jumpTarget   = {ifidPc_q[31:28], index26_d, 2'b00};
  end

  // Next-PC select; a not-taken branch falls through to the sequential PC.
  always_comb begin
    nextPc = pcPlus4;
    unique case (npc_sel)
      SEL_SEQ:    nextPc = pcPlus4;
      SEL_BRANCH: nextPc = br_taken ? branchTarget : pcPlus4;
      SEL_JUMP:   nextPc = jumpTarget;
      SEL_JR:     nextPc = rs_fwd_d;
      default:    nextPc = pcPlus4;
    endcase
  end

  // A fetch is faulty when the PC is misaligned or outside instruction memory;
  // this also covers the PC wrapping past 32'hFFFF_FFFC to zero.
  always_comb begin
    fetchFault = (fetchPc_q[1:0] != 2'b00)
              || (fetchPc_q < PC_INIT)
              || ({1'b0, fetchPc_q} >= PC_LIMIT);
  end

  // Next-state for PC and IF/ID: flush beats stall for IF/ID, while the PC
  // only ever listens to stall.
  always_comb begin
    fetchPc_d   = stall ? fetchPc_q : nextPc;
    ifidInstr_d = ifidInstr_q;
    ifidPc_d    = ifidPc_q;
    ifidPc8_d   = ifidPc8_q;
    ifidValid_d = ifidValid_q;
    ifidFault_d = ifidFault_q;
    if (flush_d) begin
      ifidInstr_d = 32'd0;
      ifidPc_d    = fetchPc_q;
      ifidPc8_d   = pcPlus8;
      ifidValid_d = 1'b0;
      ifidFault_d = 1'b0;
    end else if (!stall) begin
      ifidInstr_d = fetchFault ? 32'd0 : instr_f;
      ifidPc_d    = fetchPc_q;
      ifidPc8_d   = pcPlus8;
      ifidValid_d = 1'b1;
      ifidFault_d = fetchFault;
    end
  end

  // Fetch PC register, restarting at the base of instruction memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchPc_q <= PC_INIT;
    end else begin
      fetchPc_q <= fetchPc_d;
    end
  end

  // IF/ID pipeline register, cleared to an invalid bubble on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifidInstr_q <= 32'd0;
      ifidPc_q    <= 32'd0;
      ifidPc8_q   <= 32'd0;
      ifidValid_q <= 1'b0;
      ifidFault_q <= 1'b0;
    end else begin
      ifidInstr_q <= ifidInstr_d;
      ifidPc_q    <= ifidPc_d;
      ifidPc8_q   <= ifidPc8_d;
      ifidValid_q <= ifidValid_d;
      ifidFault_q <= ifidFault_d;
    end
  end

  assign pc_f    = fetchPc_q;
  assign instr_d = ifidInstr_q;
  assign pc_d    = ifidPc_q;
  assign pc8_d   = ifidPc8_q;
  assign valid_d = ifidValid_q;
  assign fault_d = ifidFault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed and randomized checks of ifu_fetch against a
// behavioural model of the fetch stage kept in this bench.
module tb_ifu_fetch;

  localparam logic [31:0] PC_INIT  = 32'h0000_3000;
  localparam int          IM_WORDS = 4096;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush_d;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [15:0] imm16_d;
  logic [25:0] index26_d;
  logic [31:0] rs_fwd_d;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        valid_d;
  logic        fault_d;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [31:0] mem [IM_WORDS];

  // Expected architectural state of the fetch stage.
  logic [31:0] mPc, mInstr, mPcD, mPc8;
  logic        mValid, mFault;

  ifu_fetch #(.PC_INIT(PC_INIT), .IM_WORDS(IM_WORDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush_d   (flush_d),
    .npc_sel   (npc_sel),
    .br_taken  (br_taken),
    .imm16_d   (imm16_d),
    .index26_d (index26_d),
    .rs_fwd_d  (rs_fwd_d),
    .instr_f   (instr_f),
    .pc_f      (pc_f),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc8_d     (pc8_d),
    .valid_d   (valid_d),
    .fault_d   (fault_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit inMemory(input logic [31:0] addr);
    longint a;
    a = longint'(addr);
    return (a >= longint'(PC_INIT)) && (a < longint'(PC_INIT) + 4 * IM_WORDS);
  endfunction

  function automatic bit isBadPc(input logic [31:0] addr);
    return (addr % 4 != 0) || !inMemory(addr);
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return mem[(addr - PC_INIT) / 4];
  endfunction

  // Instruction memory with a combinational read; outside memory it returns
  // a recognisable non-zero pattern so a missing nop substitution shows up.
  always_comb begin
    instr_f = 32'hBAD0_BAD0;
    if (inMemory(pc_f)) instr_f = memWord(pc_f);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".pc_f"},    pc_f,           mPc);
    checkOutput({tag, ".instr_d"}, instr_d,        mInstr);
    checkOutput({tag, ".pc_d"},    pc_d,           mPcD);
    checkOutput({tag, ".pc8_d"},   pc8_d,          mPc8);
    checkOutput({tag, ".valid_d"}, 32'(valid_d),   32'(mValid));
    checkOutput({tag, ".fault_d"}, 32'(fault_d),   32'(mFault));
  endtask

  task automatic modelReset();
    mPc = PC_INIT; mInstr = 0; mPcD = 0; mPc8 = 0; mValid = 0; mFault = 0;
  endtask

  // One clock edge of the fetch stage, from the rules: choose the next PC,
  // then load/hold/flush the IF/ID register using the pre-edge PC.
  task automatic modelEdge();
    logic [31:0] target;
    int          offset;
    target = mPc + 4;
    if (npc_sel == 2'd1 && br_taken) begin
      offset = int'($signed(imm16_d)) * 4;
      target = mPcD + 4 + 32'(offset);
    end else if (npc_sel == 2'd2) begin
      target = (mPcD & 32'hF000_0000) + {6'd0, index26_d} * 4;
    end else if (npc_sel == 2'd3) begin
      target = rs_fwd_d;
    end
    if (flush_d) begin
      mInstr = 0; mPcD = mPc; mPc8 = mPc + 8; mValid = 0; mFault = 0;
    end else if (!stall) begin
      mFault = isBadPc(mPc);
      mInstr = mFault ? 32'd0 : memWord(mPc);
      mPcD = mPc; mPc8 = mPc + 8; mValid = 1;
    end
    if (!stall) mPc = target;
  endtask

  task automatic applyStimulus(input logic st, input logic fl, input logic [1:0] sel,
                               input logic bt, input logic [15:0] imm,
                               input logic [25:0] idx, input logic [31:0] rs,
                               input string tag);
    stall = st; flush_d = fl; npc_sel = sel; br_taken = bt;
    imm16_d = imm; index26_d = idx; rs_fwd_d = rs;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(tag);
  endtask

  task automatic seq(input string tag);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, tag);
  endtask

  task automatic jr(input logic [31:0] rs, input string tag);
    applyStimulus(1'b0, 1'b0, 2'd3, 1'b0, 16'd0, 26'd0, rs, tag);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rs;
    for (int i = 0; i < IM_WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h1; mem[1] = 32'h2; mem[2] = 32'h3;

    reset = 1'b0; stall = 0; flush_d = 0; npc_sel = 0; br_taken = 0;
    imm16_d = 0; index26_d = 0; rs_fwd_d = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    @(negedge clk);
    reset = 1'b1;

    // Sequential fetch from the base of memory.
    seq("seq1");
    checkOutput("seq1.instr", instr_d, 32'h1);
    seq("seq2");
    checkOutput("seq2.pc_f", pc_f, 32'h3008);
    checkOutput("seq2.pc8", pc8_d, 32'h300C);

    // Two stalled edges, then resume.
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, "stall1");
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 16'd0, 26'h3FF_FFFF, 32'd0, "stall2");
    checkOutput("stall2.pc_f", pc_f, 32'h3008);
    checkOutput("stall2.instr", instr_d, 32'h2);
    seq("resume");
    checkOutput("resume.pc_f", pc_f, 32'h300C);
    checkOutput("resume.instr", instr_d, 32'h3);

    // Taken backward branch at 0x3004, delay slot still fetched.
    jr(32'h3004, "toBeq");
    seq("beqInD");
    applyStimulus(1'b0, 1'b0, 2'd1, 1'b1, 16'hFFFF, 26'd0, 32'd0, "beqTaken");
    checkOutput("beqTaken.pc_f", pc_f, 32'h3004);
    checkOutput("beqTaken.slot", pc_d, 32'h3008);
    seq("beqInD2");
    applyStimulus(1'b0, 1'b0, 2'd1, 1'b0, 16'hFFFF, 26'd0, 32'd0, "beqNotTaken");
    checkOutput("beqNotTaken.pc_f", pc_f, 32'h300C);

    // j at 0x3000.
    jr(32'h3000, "toJ");
    seq("jInD");
    applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 16'd0, 26'h000_0C10, 32'd0, "jump");
    checkOutput("jump.pc_f", pc_f, 32'h3040);

    // jr to a misaligned and to an out-of-range address.
    jr(32'h3002, "jrMis");
    seq("misInD");
    checkOutput("misInD.fault", 32'(fault_d), 32'd1);
    checkOutput("misInD.pc_d", pc_d, 32'h3002);
    checkOutput("misInD.instr", instr_d, 32'd0);
    jr(32'h7000, "jrFar");
    seq("farInD");
    checkOutput("farInD.fault", 32'(fault_d), 32'd1);

    // Wrap-around past the top of the address space.
    jr(32'hFFFF_FFFC, "jrTop");
    seq("wrap");
    checkOutput("wrap.pc_f", pc_f, 32'd0);
    seq("wrapInD");
    checkOutput("wrapInD.fault", 32'(fault_d), 32'd1);
    jr(PC_INIT, "home");

    // Stall and flush together: PC held, IF/ID becomes a bubble.
    seq("preFlush");
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, "stallFlush");
    checkOutput("stallFlush.valid", 32'(valid_d), 32'd0);

    // Randomized traffic, steered back into memory when the PC wanders off.
    for (int n = 0; n < 400; n++) begin
      logic st, fl, bt;
      logic [1:0] sel;
      st  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      bt  = $urandom_range(0, 1) == 1;
      sel = 2'($urandom_range(0, 3));
      rs  = PC_INIT + 4 * $urandom_range(0, IM_WORDS - 1);
      if ($urandom_range(0, 5) == 0) rs = $urandom;
      if (!inMemory(mPc) && $urandom_range(0, 1) == 1) sel = 2'd3;
      applyStimulus(st, fl, sel, bt, 16'($urandom), 26'($urandom), rs, "rand");
    end

    // Asynchronous reset in the middle of a stall.
    stall = 1'b1;
    @(posedge clk);
    modelEdge();
    #3;
    reset = 1'b0;
    modelReset();
    #1;
    checkAll("asyncReset");
    checkOutput("asyncReset.valid", 32'(valid_d), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seq("afterReset");
    checkOutput("afterReset.instr", instr_d, 32'h1);
    for (int n = 0; n < 20; n++) seq("tail");

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
